// File: rtl/xor_pattern_seq.sv
// xor_pattern_seq: walks 16 patterns onto A..D, holds each, and checks the XOR stage's E/F/G
module xor_pattern_seq #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
   input  logic       E,
   input  logic       F,
   input  logic       G,
   output logic       busy,
   output logic       done,
   output logic [4:0] err_cnt,
   output logic [3:0] pat
);
   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 2);
   state_t     r_state, w_state_nxt;
   logic [7:0] r_hold, w_hold_nxt;
   logic [3:0] r_pat, w_pat_nxt;
   logic [4:0] r_err, w_err_nxt;
   logic       r_busy, r_done;
   logic       w_mis;
   assign w_mis   = (E != (r_pat[0] ^ r_pat[1])) || (F != (r_pat[2] ^ r_pat[3])) || (G != ^r_pat);
   assign A       = r_pat[0];
   assign B       = r_pat[1];
   assign C       = r_pat[2];
   assign D       = r_pat[3];
   assign pat     = r_pat;
   assign err_cnt = r_err;
   assign busy    = r_busy;
   assign done    = r_done;
   // next-state, pattern, hold and error-count decisions
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_pat_nxt   = r_pat;
      w_err_nxt   = r_err;
      case (r_state)
         IDLE: begin
            w_pat_nxt  = '0;
            w_hold_nxt = '0;
            if (start && !abort) begin
               w_state_nxt = DRIVE;
               w_err_nxt   = '0;
            end
         end
         DRIVE: begin
            if (abort) begin
               w_state_nxt = IDLE;
               w_pat_nxt   = '0;
               w_hold_nxt  = '0;
            end else if (r_hold == HOLD_LAST) begin
               w_state_nxt = SAMPLE;
            end else begin
               w_hold_nxt = r_hold + 8'd1;
            end
         end
         SAMPLE: begin
            w_hold_nxt = '0;
            if (abort) begin
               w_state_nxt = IDLE;
               w_pat_nxt   = '0;
            end else begin
               if (w_mis && r_err != 5'd16) w_err_nxt = r_err + 5'd1;
               if (r_pat == 4'd15) begin
                  w_state_nxt = DONE;
               end else begin
                  w_state_nxt = DRIVE;
                  w_pat_nxt   = r_pat + 4'd1;
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
            w_pat_nxt   = '0;
            w_hold_nxt  = '0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_pat_nxt   = '0;
            w_hold_nxt  = '0;
         end
      endcase
   end
   // state and output registers; busy/done are registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_hold  <= '0;
         r_pat   <= '0;
         r_err   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         r_pat   <= w_pat_nxt;
         r_err   <= w_err_nxt;
         r_busy  <= (w_state_nxt == DRIVE) || (w_state_nxt == SAMPLE);
         r_done  <= (w_state_nxt == DONE);
      end
   end
endmodule

// File: tb/tb_xor_pattern_seq.sv
// tb_xor_pattern_seq: directed checks of run timing, fault counting, abort, reset and start handling
module tb_xor_pattern_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       A, B, C, D, E, F, G;
   logic       busy, done;
   logic [4:0] err_cnt;
   logic [3:0] pat;
   int         mode = 0;
   int         passed = 0;
   int         total = 0;

   xor_pattern_seq #(.HOLD_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
      .busy(busy), .done(done), .err_cnt(err_cnt), .pat(pat)
   );

   always #5 clk = ~clk;

   // downstream XOR stage model with selectable faults
   assign E = (mode == 2) ? ~(A ^ B) : (A ^ B);
   assign F = (mode == 2) ? ~(C ^ D) : (C ^ D);
   assign G = (mode == 1) ? 1'b0 : (mode == 2) ? ~(A ^ B ^ C ^ D) : (A ^ B ^ C ^ D);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic run(input logic [4:0] exp_err, input int dup);
      int n;
      int dp;
      n = 0;
      dp = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (busy && n < 200) begin
         if (n % 4 == 0) begin
            chk("pat_step", 32'(pat), n / 4);
            chk("abcd_map", 32'({D, C, B, A}), n / 4);
         end
         if (done) dp++;
         start = (n == dup || n == dup + 2);
         n++;
         tick();
      end
      start = 1'b0;
      chk("busy_len", n, 64);
      chk("done_pulse", 32'(done), 1);
      chk("err_at_done", 32'(err_cnt), 32'(exp_err));
      chk("pat_in_done", 32'(pat), 15);
      tick();
      chk("done_once", 32'(done), 0);
      chk("idle_pat", 32'(pat), 0);
      chk("idle_abcd", 32'({D, C, B, A}), 0);
      chk("err_hold", 32'(err_cnt), 32'(exp_err));
      chk("no_early_done", dp, 0);
   endtask

   initial begin
      int k;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_pat", 32'(pat), 0);
      chk("rst_err", 32'(err_cnt), 0);
      chk("rst_abcd", 32'({D, C, B, A}), 0);

      mode = 0;
      run(5'd0, 1000);
      mode = 1;
      run(5'd8, 1000);
      mode = 2;
      run(5'd16, 1000);
      tick();
      tick();
      chk("err16_hold", 32'(err_cnt), 16);

      mode = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_err_clr", 32'(err_cnt), 0);
      k = 0;
      while (pat != 4'd5 && k < 200) begin
         k++;
         tick();
      end
      chk("reach_pat5", 32'(k < 200), 1);
      chk("err_before_abort", 32'(err_cnt), 3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_pat", 32'(pat), 0);
      chk("abort_abcd", 32'({D, C, B, A}), 0);
      chk("abort_err", 32'(err_cnt), 3);
      chk("abort_done", 32'(done), 0);
      tick();
      tick();
      chk("abort_no_done", 32'(done), 0);
      chk("abort_idle", 32'(busy), 0);

      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (pat != 4'd9 && k < 200) begin
         k++;
         tick();
      end
      chk("reach_pat9", 32'(k < 200), 1);
      tick();
      tick();
      tick();
      chk("pat9_sample_pat", 32'(pat), 9);
      chk("err_before_rst", 32'(err_cnt), 5);
      rst = 1'b1;
      start = 1'b1;
      abort = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_done", 32'(done), 0);
      chk("mrst_pat", 32'(pat), 0);
      chk("mrst_err", 32'(err_cnt), 0);
      chk("mrst_abcd", 32'({D, C, B, A}), 0);
      tick();
      chk("mrst_no_done", 32'(done), 0);

      mode = 0;
      run(5'd0, 5);
      run(5'd0, 3);

      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", 32'(busy), 0);
      chk("start_abort_pat", 32'(pat), 0);
      tick();
      chk("start_abort_stay", 32'(busy), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
